// File: rtl/ss_seq_pkg.sv
// Shared definitions for the save-state sequencer: bus widths, default slot
// layout, FSM state encoding and the LOAD slot-stepping helper.
package ss_seq_pkg;

   localparam int SS_AW        = 8;
   localparam int SS_DW        = 8;
   localparam int SS_LEN_DEF   = 128;
   localparam int IDX_SLOT_DEF = 127;

   typedef enum logic [2:0] {
      IDLE, SV_SET, SV_MEM, LD_CHK, LD_CMP, LD_RD, LD_WR, FIN
   } state_t;

   // Next LOAD slot after cur, stepping over the read-only index slot.
   // One bit wider than the slot address so SS_LEN==256 terminates by compare.
   function automatic logic [SS_AW:0] next_slot(input logic [SS_AW-1:0] cur,
                                                input logic [SS_AW-1:0] skip);
      logic [SS_AW:0] n;
      n = {1'b0, cur} + {{SS_AW{1'b0}}, 1'b1};
      if (n == {1'b0, skip})
         n = n + {{SS_AW{1'b0}}, 1'b1};
      return n;
   endfunction

endpackage

// File: rtl/ss_seq_mem_port.sv
// State-memory request port: holds req/we/addr/wdata from a start pulse until
// mem_ack, latches the read byte, and reports completion one cycle later.
module ss_mem_port
   import ss_seq_pkg::*;
#(
   parameter int AW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [SS_DW-1:0] wdat,
   output logic             done,
   output logic [SS_DW-1:0] rdat,
   output logic             mem_req,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [SS_DW-1:0] mem_wdat,
   input  logic [SS_DW-1:0] mem_rdat,
   input  logic             mem_ack
);

   // Handshake: mem_req rises on start and holds with mem_we/mem_addr/mem_wdat
   // frozen until a cycle with mem_ack; mem_ack seen while mem_req is low is
   // ignored, start seen while a request is open is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_wdat <= '0;
         rdat     <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (mem_req) begin
            if (mem_ack) begin
               mem_req <= 1'b0;
               rdat    <= mem_rdat;
               done    <= 1'b1;
            end
         end else if (start) begin
            mem_req  <= 1'b1;
            mem_we   <= we;
            mem_addr <= addr;
            mem_wdat <= wdat;
         end
      end
   end

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: SAVE copies every mapper slot to state memory, LOAD
// checks the stored map index and then writes the stored slots back.
module ss_seq
   import ss_seq_pkg::*;
#(
   parameter int          SS_LEN   = SS_LEN_DEF,
   parameter int          IDX_SLOT = IDX_SLOT_DEF,
   parameter int          MEM_AW   = 16,
   parameter int unsigned BASE     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_save,
   input  logic              cmd_load,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              ss_tick,
   output logic              ss_act,
   output logic              ss_we,
   output logic [SS_AW-1:0]  ss_addr,
   output logic [SS_DW-1:0]  ss_wdat,
   input  logic [SS_DW-1:0]  ss_rdat,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [SS_DW-1:0]  mem_wdat,
   input  logic [SS_DW-1:0]  mem_rdat,
   input  logic              mem_ack
);

   localparam logic [SS_AW-1:0] LAST  = SS_AW'(SS_LEN - 1);
   localparam logic [SS_AW-1:0] IDX8  = SS_AW'(IDX_SLOT);
   localparam logic [SS_AW:0]   LEN9  = (SS_AW + 1)'(SS_LEN);
   localparam logic [SS_AW:0]   FIRST = (IDX_SLOT == 0) ? 9'd1 : 9'd0;

   state_t            state, state_nx;
   logic [SS_AW-1:0]  idx, idx_nx, addr_nx, mp_slot;
   logic [SS_AW:0]    nxt;
   logic              idx_ld, addr_ld, wdat_ld, err_set, err_clr;
   logic              mp_start, mp_we, mp_done;
   logic [SS_DW-1:0]  mp_wdat, mp_rdat;
   logic [MEM_AW-1:0] mp_addr;

   assign nxt     = next_slot(idx, IDX8);
   assign mp_addr = MEM_AW'(BASE) + MEM_AW'(mp_slot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mp_start = 1'b0;
      mp_we    = 1'b0;
      mp_slot  = idx;
      mp_wdat  = '0;
      idx_ld   = 1'b0;
      idx_nx   = idx;
      addr_ld  = 1'b0;
      addr_nx  = ss_addr;
      wdat_ld  = 1'b0;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_save) begin
               state_nx = SV_SET;
               err_clr  = 1'b1;
               idx_ld   = 1'b1;
               idx_nx   = '0;
               addr_ld  = 1'b1;
               addr_nx  = '0;
            end else if (cmd_load) begin
               state_nx = LD_CHK;
               err_clr  = 1'b1;
               idx_ld   = 1'b1;
               idx_nx   = '0;
               addr_ld  = 1'b1;
               addr_nx  = IDX8;
               mp_start = 1'b1;
               mp_slot  = IDX8;
            end
         end
         SV_SET: begin
            // Mapper readback is sampled on the tick the address has been held for.
            if (ss_tick) begin
               mp_start = 1'b1;
               mp_we    = 1'b1;
               mp_wdat  = ss_rdat;
               state_nx = SV_MEM;
            end
         end
         SV_MEM: begin
            if (mp_done) begin
               if (idx == LAST) begin
                  state_nx = FIN;
               end else begin
                  idx_ld   = 1'b1;
                  idx_nx   = idx + 1'b1;
                  addr_ld  = 1'b1;
                  addr_nx  = idx + 1'b1;
                  state_nx = SV_SET;
               end
            end
         end
         LD_CHK: begin
            if (mp_done) state_nx = LD_CMP;
         end
         LD_CMP: begin
            if (ss_tick) begin
               if (mp_rdat != ss_rdat) begin
                  err_set  = 1'b1;
                  state_nx = FIN;
               end else if (FIRST < LEN9) begin
                  idx_ld   = 1'b1;
                  idx_nx   = FIRST[SS_AW-1:0];
                  mp_start = 1'b1;
                  mp_slot  = FIRST[SS_AW-1:0];
                  state_nx = LD_RD;
               end else begin
                  state_nx = FIN;
               end
            end
         end
         LD_RD: begin
            if (mp_done) begin
               wdat_ld  = 1'b1;
               addr_ld  = 1'b1;
               addr_nx  = idx;
               state_nx = LD_WR;
            end
         end
         LD_WR: begin
            // ss_we holds across exactly this tick; address/data stay put until the next read completes.
            if (ss_tick) begin
               if (nxt < LEN9) begin
                  idx_ld   = 1'b1;
                  idx_nx   = nxt[SS_AW-1:0];
                  mp_start = 1'b1;
                  mp_slot  = nxt[SS_AW-1:0];
                  state_nx = LD_RD;
               end else begin
                  state_nx = FIN;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE) && (state != FIN);
      ss_act = busy;
      done   = (state == FIN);
      ss_we  = (state == LD_WR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         ss_addr <= '0;
         ss_wdat <= '0;
         err     <= 1'b0;
      end else begin
         if (idx_ld)  idx     <= idx_nx;
         if (addr_ld) ss_addr <= addr_nx;
         if (wdat_ld) ss_wdat <= mp_rdat;
         if (err_clr)      err <= 1'b0;
         else if (err_set) err <= 1'b1;
      end
   end

   ss_mem_port #(.AW(MEM_AW)) u_mem_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (mp_start),
      .we       (mp_we),
      .addr     (mp_addr),
      .wdat     (mp_wdat),
      .done     (mp_done),
      .rdat     (mp_rdat),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdat (mem_wdat),
      .mem_rdat (mem_rdat),
      .mem_ack  (mem_ack)
   );

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: mapper and state-memory models, SAVE/LOAD/mismatch/reset
// scenarios with randomized pacing, scoreboarded mapper writes.
module tb_ss_seq;

   localparam int          SS_LEN   = 128;
   localparam int          IDX_SLOT = 127;
   localparam int          MEM_AW   = 16;
   localparam int unsigned BASE     = 32'hFFC0;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_save = 1'b0, cmd_load = 1'b0, ss_tick = 1'b0, mem_ack = 1'b0;
   logic [7:0]        mem_rdat = 8'h00;
   logic [7:0]        ss_rdat, ss_addr, ss_wdat, mem_wdat;
   logic              busy, done, err, ss_act, ss_we, mem_req, mem_we;
   logic [MEM_AW-1:0] mem_addr;

   logic [7:0] map_reg [0:255];
   logic [7:0] mem     [0:65535];
   logic [7:0] exp_img [0:255];
   logic [15:0] exp_q[$];

   int checks = 0, errors = 0;
   int tick_per = 6, tick_cnt = 0, mem_lat = 3, mem_cnt = 0;
   bit mem_busy = 0, inj_ack = 0;
   logic [MEM_AW-1:0] op_addr;
   logic              op_we;
   logic [7:0]        op_wdat;
   int rd_cnt, wr_cnt, we_pulses, done_cnt, act_cycles, req_cycles, ticks_in_we;
   logic prev_we = 1'b0, prev_done = 1'b0;
   logic [15:0] prev_bus;

   assign ss_rdat = map_reg[ss_addr];

   always #5 clk = ~clk;

   ss_seq #(.SS_LEN(SS_LEN), .IDX_SLOT(IDX_SLOT), .MEM_AW(MEM_AW), .BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save), .cmd_load(cmd_load),
      .busy(busy), .done(done), .err(err), .ss_tick(ss_tick),
      .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
      .mem_rdat(mem_rdat), .mem_ack(mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; the monitor then looks at the values
   // the DUT will sample on the coming rising edge.
   always @(negedge clk) begin
      if (tick_cnt >= tick_per - 1) begin ss_tick = 1'b1; tick_cnt = 0; end
      else begin ss_tick = 1'b0; tick_cnt++; end
      mem_ack = 1'b0;
      if (!rst_n) begin
         mem_busy = 0;
      end else if (inj_ack) begin
         mem_ack  = 1'b1;
         mem_rdat = 8'h77;
         inj_ack  = 0;
      end else if (mem_req) begin
         if (!mem_busy) begin
            mem_busy = 1; mem_cnt = mem_lat;
            op_addr = mem_addr; op_we = mem_we; op_wdat = mem_wdat;
         end else begin
            check("mem_hold", {7'd0, mem_we, mem_addr, mem_wdat}, {7'd0, op_we, op_addr, op_wdat});
         end
         if (mem_cnt == 0) begin
            mem_ack  = 1'b1;
            mem_busy = 0;
            if (op_we) begin mem[op_addr] = op_wdat; wr_cnt++; end
            else begin mem_rdat = mem[op_addr]; rd_cnt++; end
         end else begin
            mem_cnt--;
         end
      end

      if (rst_n) begin
         if (mem_req) req_cycles++;
         if (ss_act)  act_cycles++;
         if (ss_we) begin
            check("we_implies_act", ss_act, 1);
            if (prev_we) check("we_bus_stable", {ss_addr, ss_wdat}, prev_bus);
            else we_pulses++;
            if (ss_tick) begin
               ticks_in_we++;
               check("ss_write_queued", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("ss_write", {ss_addr, ss_wdat}, exp_q.pop_front());
               map_reg[ss_addr] = ss_wdat;
            end
         end else if (prev_we) begin
            check("we_one_tick", ticks_in_we, 1);
            ticks_in_we = 0;
         end
         if (done) begin
            done_cnt++;
            check("done_width", prev_done, 0);
         end
         prev_we   = ss_we;
         prev_bus  = {ss_addr, ss_wdat};
         prev_done = done;
      end else begin
         prev_we = 1'b0; prev_done = 1'b0; ticks_in_we = 0;
      end
   end

   task automatic clear_counts();
      rd_cnt = 0; wr_cnt = 0; we_pulses = 0; done_cnt = 0; act_cycles = 0; req_cycles = 0;
   endtask

   task automatic pulse(input bit s, input bit l);
      @(negedge clk); cmd_save = s; cmd_load = l;
      @(negedge clk); cmd_save = 1'b0; cmd_load = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
      check({tag, "_done_seen"}, done_cnt != 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic fill_mem_range(input logic [7:0] v);
      for (int n = 0; n < SS_LEN; n++) mem[16'(BASE + n)] = v;
   endtask

   task automatic check_save_image(input string tag);
      for (int n = 0; n < SS_LEN; n++) check(tag, mem[16'(BASE + n)], exp_img[n]);
      check({tag, "_writes"}, wr_cnt, SS_LEN);
      check({tag, "_reads"}, rd_cnt, 0);
      check({tag, "_we_pulses"}, we_pulses, 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) map_reg[i] = 8'h00;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);      check("rst_done", done, 0);
      check("rst_err", err, 0);        check("rst_ss_act", ss_act, 0);
      check("rst_ss_we", ss_we, 0);    check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);  check("rst_ss_addr", ss_addr, 0);
      check("rst_ss_wdat", ss_wdat, 0); check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdat", mem_wdat, 0);
      #2 rst_n = 1'b1;

      // SAVE with simultaneous commands; a later LOAD while busy is dropped
      for (int n = 0; n < SS_LEN; n++) map_reg[n] = (n == IDX_SLOT) ? 8'd24 : (8'(n) ^ 8'h5A);
      for (int n = 0; n < SS_LEN; n++) exp_img[n] = (n == IDX_SLOT) ? 8'd24 : (8'(n) ^ 8'h5A);
      fill_mem_range(8'hEE);
      tick_per = $urandom_range(4, 8);
      mem_lat = 3;
      clear_counts();
      pulse(1, 1);
      check("save_busy_after_accept", busy, 1);
      repeat (20) @(negedge clk);
      pulse(0, 1);
      wait_done(20000, "save1");
      repeat (200) @(negedge clk);
      check_save_image("save1_img");
      check("save1_err", err, 0);
      check("save1_busy_end", busy, 0);

      // LOAD with matching index
      for (int n = 0; n < SS_LEN; n++) begin
         mem[16'(BASE + n)] = (n == IDX_SLOT) ? 8'd24 : 8'(n + 1);
         map_reg[n] = 8'($urandom);
         if (n != IDX_SLOT) exp_q.push_back({8'(n), 8'(n + 1)});
      end
      map_reg[IDX_SLOT] = 8'd24;
      mem_lat = $urandom_range(0, 5);
      tick_per = $urandom_range(3, 9);
      clear_counts();
      pulse(0, 1);
      wait_done(20000, "load1");
      check("load1_we_pulses", we_pulses, SS_LEN - 1);
      check("load1_q_empty", exp_q.size(), 0);
      check("load1_err", err, 0);
      check("load1_done_cnt", done_cnt, 1);
      check("load1_reads", rd_cnt, SS_LEN);
      check("load1_writes", wr_cnt, 0);
      check("load1_idx_slot_kept", map_reg[IDX_SLOT], 24);

      // LOAD with mismatching index
      mem[16'(BASE + IDX_SLOT)] = 8'd26;
      clear_counts();
      pulse(0, 1);
      wait_done(5000, "load_bad");
      check("load_bad_err", err, 1);
      check("load_bad_done_cnt", done_cnt, 1);
      check("load_bad_we_pulses", we_pulses, 0);
      check("load_bad_reads", rd_cnt, 1);
      repeat (20) @(negedge clk);
      check("load_bad_err_sticky", err, 1);

      // Reset in the middle of a write burst; late ack afterwards
      mem[16'(BASE + IDX_SLOT)] = 8'd24;
      for (int n = 0; n < SS_LEN; n++) begin
         if (n != IDX_SLOT) begin
            mem[16'(BASE + n)] = 8'($urandom);
            exp_q.push_back({8'(n), mem[16'(BASE + n)]});
         end
      end
      clear_counts();
      pulse(0, 1);
      check("load_err_cleared_on_accept", err, 0);
      begin
         int n = 0;
         while (!(we_pulses >= 3 && ss_we) && n < 5000) begin @(negedge clk); n++; end
         check("abort_reach_ld_wr", ss_we, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_ss_we", ss_we, 0);
      check("abort_ss_act", ss_act, 0);
      check("abort_busy", busy, 0);
      check("abort_mem_req", mem_req, 0);
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      exp_q.delete();
      clear_counts();
      inj_ack = 1;
      repeat (60) @(negedge clk);
      check("late_ack_req_cycles", req_cycles, 0);
      check("late_ack_act_cycles", act_cycles, 0);
      check("late_ack_done_cnt", done_cnt, 0);
      check("late_ack_busy", busy, 0);

      // Slow memory and slow tick, random mapper image
      tick_per = 12;
      mem_lat = 50;
      for (int n = 0; n < SS_LEN; n++) begin
         map_reg[n] = 8'($urandom);
         exp_img[n] = map_reg[n];
      end
      fill_mem_range(8'hEE);
      clear_counts();
      pulse(1, 0);
      wait_done(30000, "save2");
      check_save_image("save2_img");

      // Restore that image into a scrambled mapper
      for (int n = 0; n < SS_LEN; n++) begin
         if (n != IDX_SLOT) begin
            map_reg[n] = ~exp_img[n];
            exp_q.push_back({8'(n), exp_img[n]});
         end
      end
      mem_lat = $urandom_range(0, 4);
      tick_per = $urandom_range(3, 7);
      clear_counts();
      pulse(0, 1);
      wait_done(20000, "load2");
      check("load2_we_pulses", we_pulses, SS_LEN - 1);
      check("load2_q_empty", exp_q.size(), 0);
      check("load2_err", err, 0);
      for (int n = 0; n < SS_LEN; n += 17) check("load2_map", map_reg[n], exp_img[n]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
